instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's 64-bit byte address. It captures the 32-bit instruction word returned in the same cycle into a small PC-tagged buffer. It then hands {pc, instruction} to decode over a valid/ready handshake, with branch redirect and flush.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset; must be 4-byte aligned
- DEPTH, 2, fetch buffer entries (power of two, ≥2)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Inst_address  out  64  byte address to instruction memory; equals PC register
- Instruction  in  32  word returned by instruction memory for Inst_address, combinational, same cycle
- branch_valid  in  1  redirect request this cycle
- branch_target  in  64  redirect byte address
- out_valid  out  1  buffer head holds a valid entry
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  64  address the head word was fetched from
- misaligned  out  1  sticky: a redirect target had bits [1:0] ≠ 0

## Operation
- State registers: pc[63:0], circular buffer of DEPTH × {pc 64, instr 32}, rd/wr pointers, count (0..DEPTH), state ∈ {FETCH, HALT}.
- pop = out_valid & out_ready.
- space = (count < DEPTH) | pop.
- FETCH, no redirect, space=1:
  - push {pc, Instruction} at wr pointer.
  - pc ← pc + 4, modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- FETCH, no redirect, space=0: pc holds and nothing is pushed (stall). Inst_address stays stable.
- Redirect, branch_valid=1 in FETCH, highest priority:
  - Buffer flushed: count ← 0, pointers reset. Any pop that cycle is still honoured by decode but the entry is discarded.
  - No push that cycle.
  - If branch_target[1:0]=0: pc ← branch_target.
  - Otherwise: misaligned ← 1, pc unchanged, state ← HALT.
- HALT:
  - No pushes, pc frozen.
  - Remaining buffer entries may still drain via pops.
  - branch_valid ignored.
  - Exit only by reset.
- count update: count + push − pop. Simultaneous push and pop at full keeps count=DEPTH.
- out_valid = (count ≠ 0). out_instr and out_pc come from the rd entry. Their values are don't-care when out_valid=0.

## Timing
- Reset (asserted low, asynchronous, any cycle including mid-stall or mid-redirect):
  - pc=RESET_PC, so Inst_address=RESET_PC.
  - count=0, out_valid=0, misaligned=0, state=FETCH.
  - Buffer contents need no reset.
- First push occurs on the first rising edge after reset deasserts.
- Latency: the word for address A is visible on out_instr/out_pc exactly 1 cycle after Inst_address=A, when the buffer was empty and decode was ready.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Redirect: Inst_address=branch_target on the cycle after branch_valid. The target's word appears on out_instr 2 cycles after branch_valid. out_valid=0 on the cycle after branch_valid.
- Handshake: out_valid, out_instr and out_pc stay stable until popped; out_valid never drops without a pop, except on redirect or reset. out_ready may toggle freely.
- misaligned rises on the edge after the bad redirect and stays high until reset.

## Test plan
- Reset then free-run, out_ready=1. Bench memory returns {A[7:0]+3, A[7:0]+2, A[7:0]+1, A[7:0]} for address A.
  - Required: out_pc 0, 4, 8, 12 on consecutive cycles.
  - Required: out_instr 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
- Backpressure: hold out_ready=0 for 5 cycles after the first push.
  - Required: count saturates at DEPTH=2 and Inst_address freezes at 8.
  - Required: after release, out_pc continues 0, 4, 8, 12 with no gap or duplicate.
- Redirect while full: branch_valid with target 0x40.
  - Required: out_valid=0 the next cycle; next accepted entry has out_pc=0x40, then 0x44.
- Redirect plus simultaneous pop: branch_valid=1 while out_ready=1 and out_valid=1.
  - Required: no stale entry from before the redirect is ever presented afterwards.
- Misaligned target 0x42.
  - Required: misaligned=1 the next cycle and pc frozen.
  - Required: buffered entries are not presented (flushed), and later branch_valid is ignored.
  - Required: reset clears to pc=RESET_PC.
- Wrap and mid-operation reset:
  - RESET_PC=0xFFFF_FFFF_FFFF_FFF8 → out_pc …FFF8, …FFFC, 0x0.
  - Assert reset between clock edges → out_valid=0 and Inst_address=RESET_PC immediately.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures the same-cycle instruction word into a
// small PC-tagged FIFO and presents {pc, instr} to decode over valid/ready.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_address,
    input  logic [31:0] Instruction,
    input  logic        branch_valid,
    input  logic [63:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        misaligned
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [63:0]        pc_reg, pc_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               misaligned_reg, misaligned_next;

    // Entries are read combinationally so the head is visible the cycle after capture.
    logic [63:0]        pc_mem    [DEPTH];
    logic [31:0]        instr_mem [DEPTH];

    logic               pop, space, push, redirect, target_ok;

    assign pop       = (count_reg != '0) && out_ready;
    assign space     = (count_reg < DEPTH_C) || pop;
    assign redirect  = (state_reg == FETCH) && branch_valid;
    assign target_ok = (branch_target[1:0] == 2'b00);
    assign push      = (state_reg == FETCH) && !branch_valid && space;

    // State register (pointers, count, pc, flags).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            misaligned_reg <= misaligned_next;
        end
    end

    // Buffer contents carry no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= pc_reg;
            instr_mem[wr_ptr_reg] <= Instruction;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        if (redirect && !target_ok) begin
            state_next = HALT;
        end
    end

    // Datapath next values; a redirect flushes and outranks push/pop bookkeeping.
    always_comb begin
        pc_next         = pc_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        count_next      = count_reg;
        misaligned_next = misaligned_reg;
        if (redirect) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
            if (target_ok) begin
                pc_next = branch_target;
            end else begin
                misaligned_next = 1'b1;
            end
        end else begin
            if (push) begin
                pc_next     = pc_reg + 64'd4;
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output logic.
    always_comb begin
        Inst_address = pc_reg;
        out_valid    = (count_reg != '0);
        out_pc       = pc_mem[rd_ptr_reg];
        out_instr    = instr_mem[rd_ptr_reg];
        misaligned   = misaligned_reg;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed phases plus random traffic,
// checked each cycle against a queue-based model of the fetch stage.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic        branch_valid;
    logic [63:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        misaligned;

    logic        w_reset;
    logic [63:0] w_inst_address;
    logic [31:0] w_instruction;
    logic        w_branch_valid;
    logic [63:0] w_branch_target;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_instr;
    logic [63:0] w_out_pc;
    logic        w_misaligned;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] q[$];
    logic [63:0] m_pc;
    bit          m_halt;
    bit          m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    assign instruction   = mem_word(inst_address);
    assign w_instruction = mem_word(w_inst_address);

    instruction_fetch_unit #(.RESET_PC(64'd0), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .Inst_address(inst_address),
        .Instruction(instruction), .branch_valid(branch_valid),
        .branch_target(branch_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .misaligned(misaligned)
    );

    instruction_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(w_reset), .Inst_address(w_inst_address),
        .Instruction(w_instruction), .branch_valid(w_branch_valid),
        .branch_target(w_branch_target), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
        .misaligned(w_misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        m_pc   = 64'd0;
        m_halt = 1'b0;
        m_mis  = 1'b0;
    endtask

    // One cycle: drive inputs, compare outputs with the model, then advance both.
    task automatic step(input logic rdy, input logic bv, input logic [63:0] tgt);
        bit popped;
        int sz;
        out_ready     = rdy;
        branch_valid  = bv;
        branch_target = tgt;
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0]);
            chk("out_instr", 64'(out_instr), 64'(mem_word(q[0])));
        end
        chk("inst_address", inst_address, m_pc);
        chk("misaligned", 64'(misaligned), 64'(m_mis));
        $display("cycle rdy=%0b bv=%0b tgt=%0h addr=%0h valid=%0b pc=%0h instr=%0h",
                 rdy, bv, tgt, inst_address, out_valid, out_pc, out_instr);
        sz     = q.size();
        popped = (sz != 0) && rdy;
        if (!m_halt && bv) begin
            q.delete();
            if (tgt[1:0] == 2'b00) m_pc = tgt;
            else begin
                m_halt = 1'b1;
                m_mis  = 1'b1;
            end
        end else begin
            if (popped) void'(q.pop_front());
            if (!m_halt && (sz < DEPTH || popped)) begin
                q.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_addr", inst_address, 64'd0);
        chk("rst_mis", 64'(misaligned), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        mreset();
    endtask

    initial begin
        logic [31:0] exp_instr [4];
        logic [63:0] wrap_exp [3];
        logic [63:0] frozen;
        exp_instr = '{32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C};
        wrap_exp  = '{WRAP_PC, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0};

        reset = 1'b0; out_ready = 1'b1; branch_valid = 1'b0; branch_target = '0;
        w_reset = 1'b0; w_out_ready = 1'b1; w_branch_valid = 1'b0; w_branch_target = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Free run
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 64'd0);
            chk("fr_pc", out_pc, 64'(k * 4));
            chk("fr_instr", 64'(out_instr), 64'(exp_instr[k]));
        end

        // Backpressure
        do_reset();
        step(1'b1, 1'b0, 64'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 64'd0);
        chk("bp_addr_frozen", inst_address, 64'd8);
        for (int k = 0; k < 4; k++) begin
            chk("bp_pc_seq", out_pc, 64'(k * 4));
            step(1'b1, 1'b0, 64'd0);
        end

        // Redirect while full
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'h40);
        chk("rd_full_valid", 64'(out_valid), 64'd0);
        chk("rd_full_addr", inst_address, 64'h40);
        step(1'b1, 1'b0, 64'd0);
        chk("rd_full_pc0", out_pc, 64'h40);
        step(1'b1, 1'b0, 64'd0);
        chk("rd_full_pc1", out_pc, 64'h44);

        // Redirect with simultaneous pop
        step(1'b1, 1'b1, 64'h100);
        chk("rd_pop_valid", 64'(out_valid), 64'd0);
        step(1'b1, 1'b0, 64'd0);
        chk("rd_pop_pc", out_pc, 64'h100);

        // Random traffic, with one asynchronous reset mid-run
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                reset = 1'b0;
                #1;
                chk("async_valid", 64'(out_valid), 64'd0);
                chk("async_addr", inst_address, 64'd0);
                @(posedge clk);
                #2;
                reset = 1'b1;
                mreset();
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 {$urandom, $urandom} & ~64'd3);
        end

        // Misaligned redirect
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        frozen = inst_address;
        step(1'b0, 1'b1, 64'h42);
        chk("mis_flag", 64'(misaligned), 64'd1);
        chk("mis_valid", 64'(out_valid), 64'd0);
        chk("mis_addr", inst_address, frozen);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 64'h80);
        chk("mis_ignore_addr", inst_address, frozen);
        chk("mis_sticky", 64'(misaligned), 64'd1);
        do_reset();
        step(1'b1, 1'b0, 64'd0);
        chk("post_mis_pc", out_pc, 64'd0);

        // Wrap instance: async reset visibility then address wrap
        #2;
        w_reset = 1'b0;
        #1;
        chk("wrap_rst_addr", w_inst_address, WRAP_PC);
        chk("wrap_rst_valid", 64'(w_out_valid), 64'd0);
        @(posedge clk);
        #2;
        w_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("wrap_valid", 64'(w_out_valid), 64'd1);
            chk("wrap_pc", w_out_pc, wrap_exp[k]);
            chk("wrap_instr", 64'(w_out_instr), 64'(mem_word(wrap_exp[k])));
            $display("wrap cycle pc=%0h instr=%0h", w_out_pc, w_out_instr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
